// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Plays a fixed 8-note chime (C3..C4 major scale) by presenting
//               a divisor and tone enable to a downstream tone generator,
//               holding each note for a number of beat ticks and following
//               it with an optional silent gap.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
  parameter logic [27:0] TICK_DIV  = 28'd2500000,
  parameter logic [3:0]  GAP_TICKS = 4'd1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [27:0] divisor_out,
  output logic        tone_en,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [27:0] TICK_LAST = TICK_DIV - 28'd1;
  localparam logic [2:0]  LAST_NOTE = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [27:0] prescaler, prescaler_next;
  logic [27:0] divisor_next;
  logic [2:0]  dur_cnt, dur_next;
  logic [3:0]  gap_cnt, gap_next;
  logic [2:0]  idx_next;
  logic        tone_next, busy_next, done_next;
  logic        tick;
  logic        advance;

  // Divisor for each note of the chime
  function automatic logic [27:0] note_div(input logic [2:0] i);
    case (i)
      3'd0:    note_div = 28'd382233;
      3'd1:    note_div = 28'd340530;
      3'd2:    note_div = 28'd303030;
      3'd3:    note_div = 28'd286352;
      3'd4:    note_div = 28'd255102;
      3'd5:    note_div = 28'd227272;
      3'd6:    note_div = 28'd202478;
      default: note_div = 28'd191110;
    endcase
  endfunction

  // Duration in beat ticks; the final note is held twice as long
  function automatic logic [2:0] note_dur(input logic [2:0] i);
    note_dur = (i == LAST_NOTE) ? 3'd4 : 3'd2;
  endfunction

  assign tick = (prescaler == TICK_LAST);

  // Next-state and next-output logic; stop overrides everything but reset
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    divisor_next   = divisor_out;
    dur_next       = dur_cnt;
    gap_next       = gap_cnt;
    idx_next       = note_idx;
    tone_next      = tone_en;
    busy_next      = busy;
    done_next      = 1'b0;
    advance        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_PLAY;
          idx_next       = 3'd0;
          divisor_next   = note_div(3'd0);
          dur_next       = note_dur(3'd0);
          tone_next      = 1'b1;
          busy_next      = 1'b1;
          prescaler_next = 28'd0;
        end
      end
      S_PLAY: begin
        prescaler_next = tick ? 28'd0 : prescaler + 28'd1;
        if (tick) begin
          if (dur_cnt == 3'd1) begin
            if (GAP_TICKS != 4'd0) begin
              // Silence the tone but keep the divisor for the gap
              tone_next  = 1'b0;
              gap_next   = GAP_TICKS;
              state_next = S_GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_next = dur_cnt - 3'd1;
          end
        end
      end
      S_GAP: begin
        prescaler_next = tick ? 28'd0 : prescaler + 28'd1;
        if (tick) begin
          if (gap_cnt == 4'd1) begin
            advance = 1'b1;
          end else begin
            gap_next = gap_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // End of a note (and its gap): either finish or load the next note
    if (advance) begin
      prescaler_next = 28'd0;
      if (note_idx == LAST_NOTE) begin
        state_next   = S_DONE;
        busy_next    = 1'b0;
        tone_next    = 1'b0;
        divisor_next = 28'd0;
        done_next    = 1'b1;
      end else begin
        state_next   = S_PLAY;
        idx_next     = note_idx + 3'd1;
        divisor_next = note_div(note_idx + 3'd1);
        dur_next     = note_dur(note_idx + 3'd1);
        tone_next    = 1'b1;
      end
    end

    if (stop) begin
      state_next     = S_IDLE;
      prescaler_next = 28'd0;
      divisor_next   = 28'd0;
      dur_next       = 3'd0;
      gap_next       = 4'd0;
      idx_next       = 3'd0;
      tone_next      = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= S_IDLE;
      prescaler   <= 28'd0;
      divisor_out <= 28'd0;
      dur_cnt     <= 3'd0;
      gap_cnt     <= 4'd0;
      note_idx    <= 3'd0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      prescaler   <= prescaler_next;
      divisor_out <= divisor_next;
      dur_cnt     <= dur_next;
      gap_cnt     <= gap_next;
      note_idx    <= idx_next;
      tone_en     <= tone_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench; two sequencers (with and without gaps)
//               share stimulus and are compared each cycle against a
//               timeline model of the melody.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;

  logic [27:0] a_div, b_div;
  logic        a_tone, b_tone, a_busy, b_busy, a_done, b_done;
  logic [2:0]  a_idx, b_idx;

  int total = 0;
  int bad   = 0;

  // model state: k = cycles since melody start, -1 when idle
  int k_m   [2] = '{-1, -1};
  int idle_i[2] = '{0, 0};
  int gap_m [2] = '{1, 0};

  int          dur_t [8] = '{2, 2, 2, 2, 2, 2, 2, 4};
  logic [27:0] div_t [8] = '{28'd382233, 28'd340530, 28'd303030, 28'd286352,
                             28'd255102, 28'd227272, 28'd202478, 28'd191110};

  melody_sequencer #(.TICK_DIV(28'd4), .GAP_TICKS(4'd1)) dut_a (
    .clock_in(clk), .reset(reset), .start(start), .stop(stop),
    .divisor_out(a_div), .tone_en(a_tone), .note_idx(a_idx),
    .busy(a_busy), .done(a_done));

  melody_sequencer #(.TICK_DIV(28'd4), .GAP_TICKS(4'd0)) dut_b (
    .clock_in(clk), .reset(reset), .start(start), .stop(stop),
    .divisor_out(b_div), .tone_en(b_tone), .note_idx(b_idx),
    .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs k cycles into a melody with gap length g ticks
  task automatic expect_at(input int k, input int g, input int idle_idx,
                           output logic [27:0] d, output logic en,
                           output int idx, output logic b, output logic dn);
    int len = (18 + 8 * g) * T;
    int pos;
    d = 28'd0; en = 1'b0; idx = idle_idx; b = 1'b0; dn = 1'b0;
    if (k >= 0 && k < len) begin
      b = 1'b1;
      pos = k;
      for (int i = 0; i < 8; i++) begin
        if (pos >= 0) begin
          if (pos < dur_t[i] * T) begin
            en = 1'b1; d = div_t[i]; idx = i;
          end else if (pos < dur_t[i] * T + g * T) begin
            d = div_t[i]; idx = i;
          end
          pos = pos - dur_t[i] * T - g * T;
        end
      end
    end else if (k == len) begin
      dn = 1'b1; idx = 7;
    end
  endtask

  task automatic model_step();
    for (int j = 0; j < 2; j++) begin
      if (reset || stop) begin
        k_m[j] = -1; idle_i[j] = 0;
      end else if (k_m[j] < 0) begin
        if (start) k_m[j] = 0;
      end else begin
        k_m[j]++;
        if (k_m[j] > (18 + 8 * gap_m[j]) * T) begin
          k_m[j] = -1; idle_i[j] = 7;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [27:0] d; logic en, b, dn; int idx;
    expect_at(k_m[0], gap_m[0], idle_i[0], d, en, idx, b, dn);
    chk("a_divisor", a_div, d);  chk("a_tone_en", a_tone, en);
    chk("a_note_idx", a_idx, idx); chk("a_busy", a_busy, b);
    chk("a_done", a_done, dn);
    expect_at(k_m[1], gap_m[1], idle_i[1], d, en, idx, b, dn);
    chk("b_divisor", b_div, d);  chk("b_tone_en", b_tone, en);
    chk("b_note_idx", b_idx, idx); chk("b_busy", b_busy, b);
    chk("b_done", b_done, dn);
  endtask

  // One clock: DUT and model see the same inputs, outputs checked mid-cycle
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int na, nb, da, db, prev;
    logic [27:0] seq[$];

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(1)); stop = 1'($urandom_range(1));
      cyc();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    cyc();
    chk("rst_busy", a_busy, 0); chk("rst_div", a_div, 0); chk("rst_tone", a_tone, 0);

    // full melody
    start = 1'b1; cyc(); start = 1'b0;
    chk("first_tone", a_tone, 1); chk("first_div", a_div, 382233);
    chk("first_idx", a_idx, 0);
    na = 1; nb = 1; da = 0; db = 0; prev = 1; seq.push_back(a_div);
    for (int i = 0; i < 110; i++) begin
      cyc();
      na += a_busy; nb += b_busy; da += a_done; db += b_done;
      if (a_tone && prev == 0) seq.push_back(a_div);
      prev = a_tone;
    end
    chk("a_busy_cycles", na, 104); chk("b_busy_cycles", nb, 72);
    chk("a_done_count", da, 1);    chk("b_done_count", db, 1);
    chk("seq_len", seq.size(), 8);
    if (seq.size() == 8) begin
      chk("seq0", seq[0], 382233); chk("seq3", seq[3], 286352);
      chk("seq7", seq[7], 191110);
    end

    // start while busy is ignored
    start = 1'b1; cyc(); start = 1'b0;
    na = 1;
    for (int i = 0; i < 115; i++) begin
      start = (i == 25);
      cyc();
      na += a_busy;
    end
    start = 1'b0;
    chk("busy_restart_ign", na, 104);

    // stop in the middle of note 3
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 200 && a_idx != 3; i++) cyc();
    chk("reach_note3", a_idx, 3);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_tone", a_tone, 0); chk("stop_div", a_div, 0);
    chk("stop_busy", a_busy, 0); chk("stop_idx", a_idx, 0);
    da = 0;
    for (int i = 0; i < 120; i++) begin cyc(); da += a_done + b_done; end
    chk("stop_no_done", da, 0);

    // start and stop together in idle
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    cyc();
    chk("ss_busy_a", a_busy, 0); chk("ss_busy_b", b_busy, 0);

    // reset during a gap, then restart
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 200 && !(a_busy && !a_tone); i++) cyc();
    chk("reach_gap", a_busy && !a_tone, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rgap_busy", a_busy, 0); chk("rgap_div", a_div, 0);
    chk("rgap_tone", a_tone, 0); chk("rgap_idx", a_idx, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_idx", a_idx, 0); chk("restart_div", a_div, 382233);
    chk("restart_tone", a_tone, 1);
    for (int i = 0; i < 110; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
